// File: rtl/ppdu_framer.sv
// IEEE 802.15.4 PPDU framer: preamble, SFD, PHR, payload and optional CRC-16/KERMIT FCS into the TX FIFO.
// Define FRAMER_FCS_EN to compute and append the FCS; undefined, the CPU supplies every PSDU byte.
module ppdu_framer #(
  parameter int unsigned  PREAMBLE_BYTES = 4,
  parameter logic [7:0]   SFD_VALUE      = 8'hA7,
  localparam int unsigned LEN_W          = 7,
  localparam int unsigned BYTE_W         = 8
) (
  input  logic              inClock,
  input  logic              inReset,
  input  logic              inStart,
  input  logic [LEN_W-1:0]  inLength,
  input  logic [BYTE_W-1:0] inPayloadData,
  input  logic              inPayloadValid,
  output logic              outPayloadReady,
  input  logic              inFull,
  output logic              outWriteEnable,
  output logic [BYTE_W-1:0] outData,
  output logic              outBusy,
  output logic              outDone,
  output logic              outLengthError
);

  localparam int unsigned CNT_W    = 7;
  localparam int unsigned CRC_W    = 16;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BYTES - 1);
`ifdef FRAMER_FCS_EN
  localparam logic [LEN_W-1:0] MIN_LEN      = LEN_W'(3);
  localparam logic [LEN_W-1:0] PAY_LAST_OFS = LEN_W'(3);
`else
  localparam logic [LEN_W-1:0] MIN_LEN      = LEN_W'(1);
  localparam logic [LEN_W-1:0] PAY_LAST_OFS = LEN_W'(1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_PHR, S_PAY, S_FCS_LO, S_FCS_HI, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  pay_last;
`ifdef FRAMER_FCS_EN
  logic [CRC_W-1:0]  crc_q, crc_d;

  // CRC-16/KERMIT, reflected polynomial, LSB of the byte first
  function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc,
                                                   input logic [BYTE_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction
`endif

  assign pay_last = CNT_W'(len_q - PAY_LAST_OFS);

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
`ifdef FRAMER_FCS_EN
      crc_q <= '0;
`endif
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
`ifdef FRAMER_FCS_EN
      crc_q <= crc_d;
`endif
    end
  end

  // Next state plus the write decode; a byte advances only on an accepted write
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    err_d           = 1'b0;
`ifdef FRAMER_FCS_EN
    crc_d           = crc_q;
`endif
    outWriteEnable  = 1'b0;
    outData         = 8'h00;
    outPayloadReady = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inStart) begin
          if (inLength >= MIN_LEN) begin
            len_d   = inLength;
            cnt_d   = '0;
`ifdef FRAMER_FCS_EN
            crc_d   = '0;
`endif
            state_d = S_PRE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        outWriteEnable = !inFull;
        if (!inFull) begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_SFD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_SFD: begin
        outData        = SFD_VALUE;
        outWriteEnable = !inFull;
        if (!inFull) state_d = S_PHR;
      end
      S_PHR: begin
        outData        = {1'b0, len_q};
        outWriteEnable = !inFull;
        if (!inFull) state_d = S_PAY;
      end
      S_PAY: begin
        outData         = inPayloadData;
        outPayloadReady = !inFull;
        outWriteEnable  = !inFull && inPayloadValid;
        if (!inFull && inPayloadValid) begin
`ifdef FRAMER_FCS_EN
          crc_d = crc_update(crc_q, inPayloadData);
`endif
          if (cnt_q == pay_last) begin
            cnt_d = '0;
`ifdef FRAMER_FCS_EN
            state_d = S_FCS_LO;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef FRAMER_FCS_EN
      S_FCS_LO: begin
        outData        = crc_q[7:0];
        outWriteEnable = !inFull;
        if (!inFull) state_d = S_FCS_HI;
      end
      S_FCS_HI: begin
        outData        = crc_q[15:8];
        outWriteEnable = !inFull;
        if (!inFull) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign outBusy        = (state_q != S_IDLE);
  assign outDone        = (state_q == S_DONE);
  assign outLengthError = err_q;

endmodule
